// File: rtl/push_pop_sequencer_pkg.sv
// Shared definitions for the PUSH/POP block-transfer sequencer: register codes,
// FSM state encoding and small helpers for counting and register mapping.
package push_pop_sequencer_pkg;

  localparam logic [3:0] REG_R0  = 4'd0;
  localparam logic [3:0] REG_SP  = 4'd8;
  localparam logic [3:0] REG_PC  = 4'd9;
  localparam logic [3:0] REG_LR  = 4'd10;
  localparam logic [3:0] REG_IMM = 4'd15;

  localparam int XFER_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_SP = 3'd1,
    ST_XFER    = 3'd2,
    ST_WB_SP   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] mask);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + {3'b000, mask[i]};
    end
    return cnt;
  endfunction

  // Mask bit 8 is the "extra" register: LR when pushing, PC when popping.
  function automatic logic [3:0] reg_code(input logic [3:0] idx, input logic is_pop);
    if (idx == 4'd8) begin
      return is_pop ? REG_PC : REG_LR;
    end
    return REG_R0 + idx;
  endfunction

endpackage

// File: rtl/push_pop_sequencer_lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a 9-bit mask.
module lowest_set_bit_encoder (
  input  logic [8:0] i_mask,
  output logic [3:0] o_idx,
  output logic       o_valid
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/push_pop_sequencer.sv
// Multi-cycle PUSH/POP controller: walks the register list one memory transfer
// per register in ascending order, then writes the updated SP back.
module push_pop_sequencer
  import push_pop_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_pop,
  input  logic [7:0]        reg_list,
  input  logic              lr_pc_bit,
  input  logic [DATA_W-1:0] regA_out,
  output logic [3:0]        regA_select,
  output logic [3:0]        write_dest,
  output logic              write_en,
  output logic [DATA_W-1:0] write_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_next_state;
  logic [8:0]        r_mask;
  logic [3:0]        r_idx;
  logic [3:0]        r_count;
  logic              r_is_pop;
  logic [ADDR_W-1:0] r_first_addr;
  logic [ADDR_W-1:0] r_final_sp;

  logic [3:0]        w_cur_idx;
  logic              w_cur_valid;
  logic [8:0]        w_cur_onehot;
  logic [3:0]        w_start_count;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_span;
  logic [3:0]        w_cur_code;

  lowest_set_bit_encoder u_lsb_enc (
    .i_mask  (r_mask),
    .o_idx   (w_cur_idx),
    .o_valid (w_cur_valid)
  );

  assign w_cur_onehot  = w_cur_valid ? (9'd1 << w_cur_idx) : 9'd0;
  assign w_start_count = popcount9({lr_pc_bit, reg_list});
  assign w_base        = ADDR_W'(regA_out);
  assign w_span        = ADDR_W'(r_count) * ADDR_W'(XFER_BYTES);
  assign w_cur_code    = reg_code(w_cur_idx, r_is_pop);
  assign busy          = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_idx        <= '0;
      r_count      <= '0;
      r_is_pop     <= 1'b0;
      r_first_addr <= '0;
      r_final_sp   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask   <= {lr_pc_bit, reg_list};
            r_count  <= w_start_count;
            r_is_pop <= is_pop;
            r_idx    <= '0;
          end
        end
        // Both PUSH values equal base - 4N: the lowest slot becomes the new SP.
        ST_LOAD_SP: begin
          r_first_addr <= r_is_pop ? w_base : (w_base - w_span);
          r_final_sp   <= r_is_pop ? (w_base + w_span) : (w_base - w_span);
        end
        ST_XFER: begin
          if (mem_ready) begin
            r_mask <= r_mask & ~w_cur_onehot;
            r_idx  <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    regA_select  = '0;
    write_dest   = '0;
    write_en     = 1'b0;
    write_in     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (w_start_count == 4'd0) ? ST_DONE : ST_LOAD_SP;
        end
      end
      ST_LOAD_SP: begin
        regA_select  = REG_SP;
        w_next_state = ST_XFER;
      end
      ST_XFER: begin
        mem_req  = 1'b1;
        mem_addr = r_first_addr + (ADDR_W'(r_idx) * ADDR_W'(XFER_BYTES));
        if (r_is_pop) begin
          write_dest = w_cur_code;
          write_in   = mem_rdata;
          write_en   = mem_ready;
        end else begin
          mem_we      = 1'b1;
          regA_select = w_cur_code;
          mem_wdata   = regA_out;
        end
        if (mem_ready && ((r_mask & ~w_cur_onehot) == 9'd0)) begin
          w_next_state = ST_WB_SP;
        end
      end
      ST_WB_SP: begin
        write_dest   = REG_SP;
        write_en     = 1'b1;
        write_in     = DATA_W'(r_final_sp);
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_push_pop_sequencer.sv
// Directed bench for push_pop_sequencer: register-file and memory models around
// the DUT, with a scoreboard of expected memory/register/done events.
module tb_push_pop_sequencer;

  localparam int W = 78;
  localparam logic [1:0] K_ST = 2'd0;
  localparam logic [1:0] K_LD = 2'd1;
  localparam logic [1:0] K_WR = 2'd2;
  localparam logic [1:0] K_DN = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_pop;
  logic [7:0]  reg_list;
  logic        lr_pc_bit;
  logic [31:0] regA_out;
  logic [3:0]  regA_select;
  logic [3:0]  write_dest;
  logic        write_en;
  logic [31:0] write_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        done;

  logic [31:0] rf [16];
  logic [31:0] mem [256];
  logic [W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int wait_cfg = 0;
  int wcnt = 0;
  bit stim_done = 0;
  bit hold_en = 0;
  logic [31:0] hold_addr;
  logic [31:0] hold_data;

  push_pop_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_pop      (is_pop),
    .reg_list    (reg_list),
    .lr_pc_bit   (lr_pc_bit),
    .regA_out    (regA_out),
    .regA_select (regA_select),
    .write_dest  (write_dest),
    .write_en    (write_en),
    .write_in    (write_in),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .done        (done)
  );

  assign regA_out  = rf[regA_select];
  assign mem_rdata = mem[mem_addr[9:2]];

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mk_ev(input logic [1:0] k, input logic [3:0] c,
                                         input logic [31:0] a, input logic [31:0] d,
                                         input logic [7:0] t);
    return {k, c, a, d, t};
  endfunction

  task automatic expect_ev(input logic [1:0] k, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] t);
    exp_q.push_back(mk_ev(k, c, a, d, t));
  endtask

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic observe(input logic [W-1:0] ev);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got=%h exp=none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL scoreboard_event got=%h exp=%h", ev, e);
      end
    end
  endtask

  // Monitor: drives the memory wait pattern, then samples outputs just after negedge.
  task automatic monitor();
    logic [7:0] rel;
    while (!stim_done) begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt >= wait_cfg) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
      #1;
      rel = 8'(cyc - t0);
      if (hold_en && mem_req && !mem_ready) begin
        check1("hold_addr", mem_addr, hold_addr);
        check1("hold_we", mem_we, 1);
        check1("hold_wdata", mem_wdata, hold_data);
      end
      if (mem_req && mem_ready) begin
        observe(mk_ev(mem_we ? K_ST : K_LD, 4'd0, mem_addr, mem_we ? mem_wdata : mem_rdata, rel));
        wcnt = 0;
      end
      if (write_en) begin
        observe(mk_ev(K_WR, write_dest, 32'd0, write_in, rel));
        rf[write_dest] = write_in;
      end
      if (done) observe(mk_ev(K_DN, 4'd0, 32'd0, 32'd0, rel));
    end
  endtask

  task automatic issue_start(input logic pop, input logic [7:0] list, input logic lr);
    @(posedge clk);
    #1;
    is_pop    = pop;
    reg_list  = list;
    lr_pc_bit = lr;
    start     = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    check1({tag, "_regA_select"}, regA_select, 0);
    check1({tag, "_write_dest"}, write_dest, 0);
    check1({tag, "_write_en"}, write_en, 0);
    check1({tag, "_write_in"}, write_in, 0);
    check1({tag, "_mem_req"}, mem_req, 0);
    check1({tag, "_mem_we"}, mem_we, 0);
    check1({tag, "_mem_addr"}, mem_addr, 0);
    check1({tag, "_mem_wdata"}, mem_wdata, 0);
    check1({tag, "_busy"}, busy, 0);
    check1({tag, "_done"}, done, 0);
  endtask

  task automatic stimulus();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // PUSH {R0,R2,LR}, SP=0x100
    rf[0] = 32'hA; rf[2] = 32'hB; rf[10] = 32'hC; rf[8] = 32'h100;
    expect_ev(K_ST, 0, 32'hF4, 32'hA, 2);
    expect_ev(K_ST, 0, 32'hF8, 32'hB, 3);
    expect_ev(K_ST, 0, 32'hFC, 32'hC, 4);
    expect_ev(K_WR, 8, 0, 32'hF4, 5);
    expect_ev(K_DN, 0, 0, 0, 6);
    issue_start(1'b0, 8'b0000_0101, 1'b1);
    drain(40);
    check1("push_sp", rf[8], 32'hF4);

    // POP {R1,PC}, SP=0xF4
    rf[8] = 32'hF4;
    mem[32'hF4 >> 2] = 32'h11;
    mem[32'hF8 >> 2] = 32'h200;
    expect_ev(K_LD, 0, 32'hF4, 32'h11, 2);
    expect_ev(K_WR, 1, 0, 32'h11, 2);
    expect_ev(K_LD, 0, 32'hF8, 32'h200, 3);
    expect_ev(K_WR, 9, 0, 32'h200, 3);
    expect_ev(K_WR, 8, 0, 32'hFC, 4);
    expect_ev(K_DN, 0, 0, 0, 5);
    issue_start(1'b1, 8'b0000_0010, 1'b1);
    drain(40);
    check1("pop_r1", rf[1], 32'h11);

    // PUSH {R7} with three wait cycles
    rf[8] = 32'h100; rf[7] = 32'h77;
    wait_cfg = 3; hold_en = 1'b1; hold_addr = 32'hFC; hold_data = 32'h77;
    expect_ev(K_ST, 0, 32'hFC, 32'h77, 5);
    expect_ev(K_WR, 8, 0, 32'hFC, 6);
    expect_ev(K_DN, 0, 0, 0, 7);
    issue_start(1'b0, 8'h80, 1'b0);
    drain(40);
    wait_cfg = 0; hold_en = 1'b0;

    // Empty list: straight to DONE
    rf[8] = 32'h100;
    expect_ev(K_DN, 0, 0, 0, 1);
    issue_start(1'b0, 8'h00, 1'b0);
    drain(20);
    check1("empty_sp", rf[8], 32'h100);

    // start pulse during XFER is ignored
    rf[8] = 32'h200; rf[3] = 32'h33; rf[4] = 32'h44;
    expect_ev(K_ST, 0, 32'h1F8, 32'h33, 2);
    expect_ev(K_ST, 0, 32'h1FC, 32'h44, 3);
    expect_ev(K_WR, 8, 0, 32'h1F8, 4);
    expect_ev(K_DN, 0, 0, 0, 5);
    issue_start(1'b0, 8'b0001_1000, 1'b0);
    @(posedge clk);
    #1;
    is_pop = 1'b1; reg_list = 8'hFF; lr_pc_bit = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(40);

    // Reset during the second XFER of a 3-register PUSH
    rf[8] = 32'h100; rf[0] = 32'h1; rf[1] = 32'h2; rf[2] = 32'h3;
    expect_ev(K_ST, 0, 32'hF4, 32'h1, 2);
    issue_start(1'b0, 8'b0000_0111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    check1("mid_reset_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check1("mid_reset_sp", rf[8], 32'h100);

    // Normal run after reset: PUSH {R0}
    expect_ev(K_ST, 0, 32'hFC, 32'h1, 2);
    expect_ev(K_WR, 8, 0, 32'hFC, 3);
    expect_ev(K_DN, 0, 0, 0, 4);
    issue_start(1'b0, 8'h01, 1'b0);
    drain(40);
    check1("after_reset_sp", rf[8], 32'hFC);

    stim_done = 1'b1;
  endtask

  initial begin
    start = 1'b0; is_pop = 1'b0; reg_list = '0; lr_pc_bit = 1'b0;
    rst_n = 1'b0; mem_ready = 1'b0;
    hold_addr = '0; hold_data = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    fork
      monitor();
      stimulus();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
